// File: rtl/multiply_seq_pkg.sv
// Shared definitions for the LPC fixed-point arithmetic blocks: FSM states and Q-format defaults.
package multiply_seq_pkg;

  localparam int LPC_WIDTH = 32;
  localparam int LPC_FRAC  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/scale_sat.sv
// Combinational back end: sign-restore, optional round (MULT_ROUND_EN), >>>FRAC and saturate
// a 2*WIDTH-bit product magnitude down to WIDTH bits.
module scale_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 15
) (
  input  logic [2*WIDTH-1:0] mag,
  input  logic               neg,
  output logic [WIDTH-1:0]   p,
  output logic               sat
);

  // One extra bit so negation and the rounding bias never wrap.
  localparam int XW = 2*WIDTH + 1;

  localparam logic signed [XW-1:0] MAX_V = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef MULT_ROUND_EN
  localparam logic signed [XW-1:0] RND =
    (FRAC > 0) ? (XW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`else
  localparam logic signed [XW-1:0] RND = '0;
`endif

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] biased;
  logic signed [XW-1:0] shifted;

  always_comb begin
    ext     = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    biased  = ext + RND;
    shifted = biased >>> FRAC;
    if (shifted > MAX_V) begin
      p   = MAX_V[WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      p   = MIN_V[WIDTH-1:0];
      sat = 1'b1;
    end else begin
      p   = shifted[WIDTH-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/multiply_seq.sv
// Sequential radix-2 signed fixed-point multiplier returning sat((A*B)>>>FRAC).
// Define MULT_ROUND_EN to round half toward +inf instead of truncating.
module multiply_seq
  import multiply_seq_pkg::*;
#(
  parameter int WIDTH   = LPC_WIDTH,
  parameter int FRAC    = LPC_FRAC,
  parameter int COUNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t               state, state_next;
  logic [COUNT_W-1:0]   count;
  logic [WIDTH-1:0]     mcand, mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     p_fix;
  logic                 sat_fix;
  logic                 accept, last_iter;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_iter = (count == COUNT_W'(WIDTH - 1));

  // Upper-half add keeps the carry, which becomes the MSB after the right shift.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: if (accept)    state_next = BUSY;
      BUSY: if (last_iter) state_next = FIX;
      FIX:                 state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  scale_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_scale_sat (
    .mag (acc),
    .neg (neg),
    .p   (p_fix),
    .sat (sat_fix)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      P         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: if (accept) begin
          // |-2^(W-1)| wraps to 2^(W-1), which is correct as an unsigned magnitude.
          mcand  <= A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
          mplier <= B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
          neg    <= A[WIDTH-1] ^ B[WIDTH-1];
          acc    <= '0;
          count  <= '0;
        end
        BUSY: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + COUNT_W'(1);
        end
        FIX: begin
          P         <= p_fix;
          sat       <= sat_fix;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_seq.sv
// Self-checking bench for multiply_seq: directed corner cases plus random pairs against a
// 64-bit integer reference model.
module tb_multiply_seq;

  localparam int W = 32;
  localparam int F = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B, P;
  logic         sat, out_valid, out_ready;

  int checks     = 0;
  int failures   = 0;
  int accept_cnt = 0;

  always #5 clk = ~clk;

  multiply_seq #(.WIDTH(W), .FRAC(F), .COUNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .P         (P),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always @(posedge clk) if (in_valid && in_ready) accept_cnt <= accept_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product, scale by 2^FRAC with floor (or round half up), then clip.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] p, output logic s);
    longint prod, q;
    longint max_v, min_v;
    max_v = 64'sd2147483647;
    min_v = -64'sd2147483648;
    prod  = longint'($signed(a)) * longint'($signed(b));
`ifdef MULT_ROUND_EN
    prod  = prod + (64'sd1 << (F - 1));
`endif
    q = prod >>> F;
    if (q > max_v)      begin p = max_v[W-1:0]; s = 1'b1; end
    else if (q < min_v) begin p = min_v[W-1:0]; s = 1'b1; end
    else                begin p = q[W-1:0];     s = 1'b0; end
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] ep;
    logic         es;
    int           n;
    model(a, b, ep, es);
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_P"}, 64'(P), 64'(ep));
    check({tag, "_sat"}, 64'(sat), 64'(es));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, 64'({out_valid, P, sat, in_ready}), 64'({1'b1, ep, es, 1'b0}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_taken"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    logic [W-1:0] ra, rb, ep;
    logic         es;
    int           n, a0, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    #12;
    check("reset_outputs", 64'({in_ready, out_valid, sat, P}), 64'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_release_in_ready", 64'(in_ready), 64'd1);

    run_op("one_by_one", 32'd32768, 32'd32768, 2);
    run_op("neg_half",   -32'sd16384, 32'd32768, 0);
    run_op("zero",       32'd0, -32'sd5, 0);
    run_op("pos_1p5",    32'd3, 32'd16384, 0);
    run_op("neg_1p5",    -32'sd3, 32'd16384, 0);
    run_op("sat_max",    32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    run_op("sat_min",    32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op("min_by_min", 32'h8000_0000, 32'h8000_0000, 0);
    run_op("stall5",     32'd123456, -32'sd98765, 5);

    for (int k = 0; k < 10; k++) begin
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op($sformatf("rand%0d", k), ra, rb, $urandom_range(0, 3));
    end

    // Back-to-back: in_valid held high, consumer always ready.
    ra = 32'd70000; rb = -32'sd45000;
    model(ra, rb, ep, es);
    a0 = accept_cnt;
    A = ra; B = rb; in_valid = 1'b1; out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      check($sformatf("b2b%0d_P", r), 64'(P), 64'(ep));
      if (r == 2) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_accepts", 64'(accept_cnt - a0), 64'd3);

    // Reset on the 10th BUSY cycle: result must vanish and never appear.
    run_op("pre_reset", 32'd300000, 32'd200000, 0);
    A = 32'd1000; B = 32'd2000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_reset", 64'({out_valid, in_ready, P}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("no_result_after_abort", 64'(seen), 64'd0);
    run_op("post_reset", -32'sd77777, 32'd55555, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
